// File: rtl/line_adapter.sv
// ============================================================================
// line_adapter
// ----------------------------------------------------------------------------
// Converts single-cycle-request cache line transactions (LINE_W bits) into
// multi-beat bursts of BEAT_W bits toward memory, and assembles read beats
// back into a full line.
//
// A request is accepted only in IDLE. Read wins over write. The burst address
// is the request address with bits [4:0] cleared, and it is held for the whole
// burst. Each cycle with burst_resp high moves one beat. After the final beat
// the adapter spends one cycle in RESP, pulsing pmem_resp, and then returns to
// IDLE.
//
// Parameters:
//   LINE_W  cache line width in bits (default 256)
//   BEAT_W  burst beat width in bits (default 64); BEATS = LINE_W / BEAT_W
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous reset, active low
//   pmem_address   line request address
//   pmem_read      line read request, held until pmem_resp
//   pmem_write     line write request, held until pmem_resp
//   pmem_wdata     line write data
//   pmem_rdata     assembled line read data; holds until the next read
//   pmem_resp      one-cycle completion pulse
//   pmem_err       (LINE_ADAPTER_TIMEOUT_EN only) stall abort flag, valid
//                  together with pmem_resp
//   burst_address  line-aligned burst address
//   burst_read     high for the whole read burst
//   burst_write    high for the whole write burst
//   burst_wdata    write beat for the current beat index
//   burst_rdata    read beat from memory
//   burst_resp     one beat accepted/returned per high cycle
//
// Optional feature (macro LINE_ADAPTER_TIMEOUT_EN):
//   Adds the pmem_err output and an 8-bit stall counter. If a burst sees 255
//   consecutive cycles without burst_resp, it aborts to RESP with pmem_err=1.
//   When the macro is not defined, bursts wait indefinitely.
// ============================================================================
module line_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pmem_address,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
`ifdef LINE_ADAPTER_TIMEOUT_EN
    output logic              pmem_err,
`endif
    output logic [31:0]       burst_address,
    output logic              burst_read,
    output logic              burst_write,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_rdata;

    logic w_in_burst;
    logic w_last_beat;
    logic w_timeout;

    assign w_in_burst  = (r_state == RD_BURST) || (r_state == WR_BURST);
    assign w_last_beat = w_in_burst && burst_resp && (r_cnt == LAST_BEAT);

`ifdef LINE_ADAPTER_TIMEOUT_EN
    logic [7:0] r_stall;
    logic       r_err;

    // The stall counter reads k-1 in the k-th cycle without a response.
    // When it reads 254 and there is still no response, that is the 255th
    // silent cycle, so the burst aborts.
    assign w_timeout = w_in_burst && !burst_resp && (r_stall == 8'd254);
    assign pmem_err  = (r_state == RESP) && r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall <= 8'd0;
            r_err   <= 1'b0;
        end else if (r_state == IDLE) begin
            r_stall <= 8'd0;
            if (pmem_read || pmem_write) begin
                r_err <= 1'b0;
            end
        end else if (w_in_burst) begin
            if (burst_resp) begin
                r_stall <= 8'd0;
            end else begin
                r_stall <= r_stall + 8'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (pmem_read) begin
                    w_next = RD_BURST;
                end else if (pmem_write) begin
                    w_next = WR_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (w_last_beat || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request latch, beat counter and read-line assembly
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_addr  <= 32'd0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // The counter is held at zero in IDLE, so every burst
                    // starts at beat 0.
                    r_cnt <= '0;
                    if (pmem_read || pmem_write) begin
                        r_addr <= pmem_address & 32'hFFFF_FFE0;
                    end
                    if (!pmem_read && pmem_write) begin
                        r_wdata <= pmem_wdata;
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (burst_resp) begin
                        r_cnt <= (r_cnt == LAST_BEAT) ? '0 : r_cnt + CNT_W'(1);
                        if (r_state == RD_BURST) begin
                            for (int i = 0; i < BEATS; i++) begin
                                if (r_cnt == CNT_W'(i)) begin
                                    r_rdata[i*BEAT_W +: BEAT_W] <= burst_rdata;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Write beat mux: select the latched-line slice for the current beat
    always_comb begin
        burst_wdata = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                burst_wdata = r_wdata[i*BEAT_W +: BEAT_W];
            end
        end
    end

    assign burst_address = r_addr;
    assign burst_read    = (r_state == RD_BURST);
    assign burst_write   = (r_state == WR_BURST);
    assign pmem_resp     = (r_state == RESP);
    assign pmem_rdata    = r_rdata;

endmodule

// File: tb/tb_line_adapter.sv
// ============================================================================
// tb_line_adapter
// ----------------------------------------------------------------------------
// Directed and randomized stimulus for line_adapter, checked against a
// line-level reference model. Expected read data is the concatenation of the
// beats that were returned. Expected write beats are the slices of the
// requested line. The expected address is the request address with its low
// 5 bits cleared.
// ============================================================================
module tb_line_adapter;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;

    typedef logic [LINE_W-1:0] vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
`ifdef LINE_ADAPTER_TIMEOUT_EN
    logic              pmem_err;
`endif
    logic [31:0]       burst_address;
    logic              burst_read;
    logic              burst_write;
    logic [BEAT_W-1:0] burst_wdata;
    logic [BEAT_W-1:0] burst_rdata;
    logic              burst_resp;

    int n_vec = 0;
    int n_err = 0;

    logic [BEAT_W-1:0] m_beat [BEATS];
    int                m_gap  [BEATS];
    logic [LINE_W-1:0] m_line;
    logic [LINE_W-1:0] m_last_rd;

    always #5 clk = ~clk;

    line_adapter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
`ifdef LINE_ADAPTER_TIMEOUT_EN
        .pmem_err     (pmem_err),
`endif
        .burst_address(burst_address),
        .burst_read   (burst_read),
        .burst_write  (burst_write),
        .burst_wdata  (burst_wdata),
        .burst_rdata  (burst_rdata),
        .burst_resp   (burst_resp)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic rand_beats(input int maxgap);
        for (int i = 0; i < BEATS; i++) begin
            m_beat[i] = {$urandom, $urandom};
            m_gap[i]  = $urandom_range(0, maxgap);
        end
    endtask

    // Line read through the adapter. Expected data is built from m_beat.
    task automatic do_read(input logic [31:0] addr, input logic also_write);
        logic [LINE_W-1:0] exp_line;
        logic [31:0]       exp_addr;
        exp_addr = {addr[31:5], 5'b00000};
        for (int i = 0; i < BEATS; i++) exp_line[i*BEAT_W +: BEAT_W] = m_beat[i];
        burst_resp   = 1'b0;
        pmem_address = addr;
        pmem_read    = 1'b1;
        pmem_write   = also_write;
        pmem_wdata   = rand_line();
        tick();
        for (int i = 0; i < BEATS; i++) begin
            for (int g = 0; g < m_gap[i]; g++) begin
                chk("rd_gap_burst_read", vec_t'(burst_read), vec_t'(1'b1));
                chk("rd_gap_burst_write", vec_t'(burst_write), vec_t'(1'b0));
                chk("rd_gap_addr", vec_t'(burst_address), vec_t'(exp_addr));
                chk("rd_gap_resp", vec_t'(pmem_resp), vec_t'(1'b0));
                burst_resp   = 1'b0;
                burst_rdata  = {$urandom, $urandom};
                pmem_address = $urandom;
                tick();
            end
            chk("rd_beat_burst_read", vec_t'(burst_read), vec_t'(1'b1));
            chk("rd_beat_burst_write", vec_t'(burst_write), vec_t'(1'b0));
            chk("rd_beat_addr", vec_t'(burst_address), vec_t'(exp_addr));
            chk("rd_beat_resp", vec_t'(pmem_resp), vec_t'(1'b0));
            burst_resp   = 1'b1;
            burst_rdata  = m_beat[i];
            pmem_address = $urandom;
            tick();
        end
        burst_resp = 1'b0;
        chk("rd_resp_pulse", vec_t'(pmem_resp), vec_t'(1'b1));
        chk("rd_resp_burst_read", vec_t'(burst_read), vec_t'(1'b0));
        chk("rd_line", pmem_rdata, exp_line);
`ifdef LINE_ADAPTER_TIMEOUT_EN
        chk("rd_err_clear", vec_t'(pmem_err), vec_t'(1'b0));
`endif
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        tick();
        chk("rd_resp_single", vec_t'(pmem_resp), vec_t'(1'b0));
        chk("rd_line_hold", pmem_rdata, exp_line);
        chk("rd_idle_burst_read", vec_t'(burst_read), vec_t'(1'b0));
        m_last_rd = exp_line;
    endtask

    // Line write through the adapter. Expected beats are slices of m_line.
    task automatic do_write(input logic [31:0] addr);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:5], 5'b00000};
        burst_resp   = 1'b0;
        pmem_address = addr;
        pmem_read    = 1'b0;
        pmem_write   = 1'b1;
        pmem_wdata   = m_line;
        tick();
        for (int i = 0; i < BEATS; i++) begin
            for (int g = 0; g <= m_gap[i]; g++) begin
                chk("wr_burst_write", vec_t'(burst_write), vec_t'(1'b1));
                chk("wr_burst_read", vec_t'(burst_read), vec_t'(1'b0));
                chk("wr_addr", vec_t'(burst_address), vec_t'(exp_addr));
                chk("wr_beat_data", vec_t'(burst_wdata), vec_t'(m_line[i*BEAT_W +: BEAT_W]));
                chk("wr_resp", vec_t'(pmem_resp), vec_t'(1'b0));
                burst_resp   = (g == m_gap[i]);
                pmem_wdata   = rand_line();
                pmem_address = $urandom;
                tick();
            end
        end
        burst_resp = 1'b0;
        chk("wr_resp_pulse", vec_t'(pmem_resp), vec_t'(1'b1));
        chk("wr_resp_burst_write", vec_t'(burst_write), vec_t'(1'b0));
        chk("wr_rdata_hold", pmem_rdata, m_last_rd);
        pmem_write = 1'b0;
        tick();
        chk("wr_resp_single", vec_t'(pmem_resp), vec_t'(1'b0));
        chk("wr_idle_burst_write", vec_t'(burst_write), vec_t'(1'b0));
    endtask

    initial begin
        rst          = 1'b0;
        pmem_address = 32'd0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        burst_rdata  = '0;
        burst_resp   = 1'b0;
        m_last_rd    = '0;
        tick();
        tick();

        // Reset state
        chk("rst_resp", vec_t'(pmem_resp), vec_t'(1'b0));
        chk("rst_burst_read", vec_t'(burst_read), vec_t'(1'b0));
        chk("rst_burst_write", vec_t'(burst_write), vec_t'(1'b0));
        chk("rst_addr", vec_t'(burst_address), vec_t'(32'd0));
        chk("rst_wdata", vec_t'(burst_wdata), vec_t'(64'd0));
        chk("rst_rdata", pmem_rdata, vec_t'(0));
        rst = 1'b1;
        tick();

        // Directed read: aligned address 0x1220, beat 0 lowest
        m_beat[0] = 64'h1111_1111_1111_1111;
        m_beat[1] = 64'h2222_2222_2222_2222;
        m_beat[2] = 64'h3333_3333_3333_3333;
        m_beat[3] = 64'h4444_4444_4444_4444;
        for (int i = 0; i < BEATS; i++) m_gap[i] = 0;
        do_read(32'h0000_1234, 1'b0);

        // Directed write with two idle cycles before each response
        m_line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        for (int i = 0; i < BEATS; i++) m_gap[i] = 2;
        do_write(32'h0000_8000);

        // Read and write requested together: the read wins
        rand_beats(2);
        do_read($urandom, 1'b1);

        // Write-back followed by an allocate in the cycle after RESP
        m_line = rand_line();
        rand_beats(1);
        do_write(32'h0000_0100);
        rand_beats(0);
        do_read(32'h0000_0200, 1'b0);

        // burst_resp while idle must not move data or the beat counter
        for (int k = 0; k < 3; k++) begin
            burst_resp  = 1'b1;
            burst_rdata = {$urandom, $urandom};
            tick();
            chk("idle_rdata", pmem_rdata, m_last_rd);
            chk("idle_burst_read", vec_t'(burst_read), vec_t'(1'b0));
            chk("idle_resp", vec_t'(pmem_resp), vec_t'(1'b0));
        end
        burst_resp = 1'b0;
        rand_beats(1);
        do_read($urandom, 1'b0);

        // Reset after two read beats discards the transaction
        pmem_address = 32'h0000_4000;
        pmem_read    = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            burst_resp  = 1'b1;
            burst_rdata = {$urandom, $urandom};
            tick();
        end
        burst_resp = 1'b0;
        pmem_read  = 1'b0;
        rst        = 1'b0;
        tick();
        chk("midrst_burst_read", vec_t'(burst_read), vec_t'(1'b0));
        chk("midrst_resp", vec_t'(pmem_resp), vec_t'(1'b0));
        chk("midrst_rdata", pmem_rdata, vec_t'(0));
        chk("midrst_addr", vec_t'(burst_address), vec_t'(32'd0));
        rst = 1'b1;
        tick();
        chk("midrst_resp_after", vec_t'(pmem_resp), vec_t'(1'b0));
        chk("midrst_idle", vec_t'(burst_read), vec_t'(1'b0));
        rand_beats(0);
        do_read(32'h0000_4000, 1'b0);

`ifdef LINE_ADAPTER_TIMEOUT_EN
        // A burst with no responses aborts in its 256th cycle
        pmem_address = 32'h0000_6000;
        pmem_read    = 1'b1;
        burst_resp   = 1'b0;
        tick();
        for (int k = 1; k <= 255; k++) begin
            chk("to_waiting", vec_t'(burst_read), vec_t'(1'b1));
            chk("to_no_resp", vec_t'(pmem_resp), vec_t'(1'b0));
            chk("to_no_err", vec_t'(pmem_err), vec_t'(1'b0));
            tick();
        end
        chk("to_resp", vec_t'(pmem_resp), vec_t'(1'b1));
        chk("to_err", vec_t'(pmem_err), vec_t'(1'b1));
        pmem_read = 1'b0;
        tick();
        chk("to_idle_resp", vec_t'(pmem_resp), vec_t'(1'b0));
        chk("to_idle_err", vec_t'(pmem_err), vec_t'(1'b0));
        chk("to_idle_burst", vec_t'(burst_read), vec_t'(1'b0));
`else
        // Without the timeout, a long stall simply waits
        rand_beats(0);
        m_gap[0] = 300;
        do_read(32'h0000_6000, 1'b0);
`endif

        // Randomized mix of reads and writes with idle noise between them
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                rand_beats(3);
                do_read($urandom, 1'b0);
            end else begin
                m_line = rand_line();
                rand_beats(3);
                do_write($urandom);
            end
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                burst_resp  = 1'($urandom_range(0, 1));
                burst_rdata = {$urandom, $urandom};
                tick();
                chk("rand_idle_rdata", pmem_rdata, m_last_rd);
                chk("rand_idle_resp", vec_t'(pmem_resp), vec_t'(1'b0));
            end
            burst_resp = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
